req_tag_alloc: RTL and testbench
================================

Name: req_tag_alloc

Overview:
- Request-side tag allocator placed directly upstream of the request history table.
- Accepts outgoing requests and allocates the lowest-numbered free tag to each one. It then issues a one-cycle init strobe (tag plus history payload) to the history table.
- Retires tags on last-completion and drives the history table's update (clear) strobe.
- Enforces an outstanding-request limit and provides a drain handshake so an upstream agent can quiesce the request path.

Parameters:
TAG_COUNT, 8, number of tags; tags 0..TAG_COUNT-1
TAG_WIDTH, log2(TAG_COUNT), tag field width (common log2 function)
HIS_WIDTH, 4, history payload width; 0 means no payload
HIS_WIDTH_I, (HIS_WIDTH ? HIS_WIDTH : 1), internal payload width
MAX_OUTSTANDING, TAG_COUNT, cap on simultaneously allocated tags, range 1..TAG_COUNT

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
req_vld  input  1  request offered
req_his  input  HIS_WIDTH_I  history payload for the request
req_rdy  output  1  request can be accepted this cycle
alloc_vld  output  1  init strobe to history table
alloc_tag  output  TAG_WIDTH  allocated tag
alloc_his  output  HIS_WIDTH_I  payload registered with the tag
cpl_vld  input  1  completion arrives
cpl_tag  input  TAG_WIDTH  tag of the completion
cpl_last  input  1  final completion for this tag
rel_vld  output  1  update strobe to history table
rel_tag  output  TAG_WIDTH  released tag
err_spurious  output  1  completion received for a tag not outstanding
outstanding  output  TAG_WIDTH+1  count of allocated tags
drain_req  input  1  request to quiesce
drain_done  output  1  quiesced

Behaviour:
- Reset (async, active-high; released synchronously by the user):
  - all tags free; outstanding=0; state RUN.
  - alloc_vld, rel_vld, err_spurious, drain_done = 0.
  - alloc_tag, rel_tag, alloc_his = 0.
- Free map:
  - TAG_COUNT-bit busy vector, registered.
  - Priority encoder selects the lowest-index free tag from the current (pre-edge) busy vector.
- req_rdy (combinational): state==RUN and at least one free tag and outstanding<MAX_OUTSTANDING. It does not depend on req_vld.
- Accept when req_vld && req_rdy. On the next edge:
  - busy[tag] is set;
  - alloc_vld=1 for exactly one cycle, with alloc_tag=tag and alloc_his=req_his (latency 1).
  - Back-to-back accepts give consecutive alloc_vld pulses with distinct tags.
- Completion:
  - cpl_vld with cpl_last=0 and busy[cpl_tag]=1: no state change.
  - cpl_vld with cpl_last=1 and busy[cpl_tag]=1: on the next edge busy[cpl_tag] is cleared, and rel_vld=1, rel_tag=cpl_tag for one cycle.
  - cpl_vld with busy[cpl_tag]=0 (either value of cpl_last): err_spurious pulses 1 cycle; no other effect; rel_vld stays 0.
- Same-cycle events:
  - Accept and release in the same cycle: outstanding unchanged.
  - A tag released this cycle is not allocatable until the next cycle, because the encoder uses the pre-edge map.
  - A completion for the tag being allocated in the same cycle is spurious.
- outstanding: +1 on accept, -1 on valid release. It never exceeds MAX_OUTSTANDING and never underflows.
- State machine:
  - RUN: req_rdy as above. drain_req=1 moves to DRAIN.
  - DRAIN: req_rdy=0; completions still processed. When outstanding==0 (registered value) move to DONE. If outstanding is already 0 on entry, DONE follows one cycle later.
  - DONE: drain_done=1, req_rdy=0. drain_req=0 moves to RUN; drain_done deasserts in the same cycle as the state change.
  - Deasserting drain_req while in DRAIN returns to RUN immediately.
- HIS_WIDTH=0: alloc_his is tied to 0 and req_his is ignored.
- Reset mid-operation: all outstanding tags are discarded and no rel_vld is generated for them.

Test Plan:
- Reset, then 3 consecutive accepts → alloc_tag 0,1,2 on consecutive cycles, alloc_his echoing req_his (e.g. 4'hA,4'h5,4'h3); outstanding reads 3.
- Fill all 8 tags → req_rdy=0. Release tag 5 (cpl_last=1) → rel_vld with rel_tag=5 next cycle; req_rdy=1 the cycle after; next accept gets tag 5.
- MAX_OUTSTANDING=2 → third request stalls with req_rdy=0 while tags 2..7 are free. Release tag 0 → next accept gets tag 0.
- Same-cycle accept and release of tag 1 with tags 0,1 busy → new tag is 2 (not 1); outstanding stays 2.
- cpl_vld on free tag 6, and cpl_last=0 on busy tag 0 → err_spurious pulses only for tag 6; tag 0 remains busy; no rel_vld.
- Drain with 2 tags outstanding → req_rdy=0 immediately; drain_done asserts one cycle after the second release. drain_req=0 → RUN and req_rdy=1. Assert rst while busy → all outputs 0 and outstanding=0 asynchronously.

Source files
------------

// File: rtl/req_tag_alloc.sv
// req_tag_alloc: request-side tag allocator feeding the request history table.
// Hands out the lowest free tag per accepted request, issues a one-cycle init
// strobe with the request payload, retires tags on last completion with an
// update strobe, flags completions for tags that are not outstanding, caps
// the number of live tags and offers a drain handshake for quiescing.
module req_tag_alloc #(
    parameter int TAG_COUNT       = 8,
    parameter int TAG_WIDTH       = $clog2(TAG_COUNT),
    parameter int HIS_WIDTH       = 4,
    parameter int HIS_WIDTH_I     = (HIS_WIDTH != 0) ? HIS_WIDTH : 1,
    parameter int MAX_OUTSTANDING = TAG_COUNT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_vld,
    input  logic [HIS_WIDTH_I-1:0] req_his,
    output logic                   req_rdy,
    output logic                   alloc_vld,
    output logic [TAG_WIDTH-1:0]   alloc_tag,
    output logic [HIS_WIDTH_I-1:0] alloc_his,
    input  logic                   cpl_vld,
    input  logic [TAG_WIDTH-1:0]   cpl_tag,
    input  logic                   cpl_last,
    output logic                   rel_vld,
    output logic [TAG_WIDTH-1:0]   rel_tag,
    output logic                   err_spurious,
    output logic [TAG_WIDTH:0]     outstanding,
    input  logic                   drain_req,
    output logic                   drain_done
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [TAG_WIDTH:0] MAX_OUT = (TAG_WIDTH + 1)'(MAX_OUTSTANDING);

    state_t                 state;
    state_t                 state_next;
    logic [TAG_COUNT-1:0]   busy;
    logic [TAG_COUNT-1:0]   acc_mask;
    logic [TAG_COUNT-1:0]   rel_mask;
    logic [TAG_WIDTH-1:0]   free_tag;
    logic                   have_free;
    logic                   below_cap;
    logic                   in_run;
    logic                   cpl_busy;
    logic                   accept;
    logic                   rel_hit;
    logic                   spurious;
    logic [HIS_WIDTH_I-1:0] his_in;

    // With no payload configured the registered payload is forced to zero
    assign his_in    = (HIS_WIDTH == 0) ? '0 : req_his;

    assign have_free = ~&busy;
    assign below_cap = outstanding < MAX_OUT;
    assign req_rdy   = in_run && have_free && below_cap;
    assign accept    = req_vld && req_rdy;
    assign rel_hit   = cpl_vld && cpl_busy && cpl_last;
    assign spurious  = cpl_vld && !cpl_busy;

    // Lowest-index free tag taken from the pre-edge busy map, so a tag being
    // released this cycle is never handed out until the following cycle
    always_comb begin
        free_tag = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_tag = TAG_WIDTH'(i);
            end
        end
    end

    // Busy lookup for the completing tag plus one-hot set/clear masks
    always_comb begin
        cpl_busy = 1'b0;
        acc_mask = '0;
        rel_mask = '0;
        for (int i = 0; i < TAG_COUNT; i++) begin
            if (cpl_tag == TAG_WIDTH'(i)) begin
                cpl_busy    = busy[i];
                rel_mask[i] = rel_hit;
            end
            if (free_tag == TAG_WIDTH'(i)) begin
                acc_mask[i] = accept;
            end
        end
    end

    // Busy map and live-tag count; accept and release never hit the same tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            outstanding <= '0;
        end else begin
            busy <= (busy | acc_mask) & ~rel_mask;
            case ({accept, rel_hit})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Registered strobes towards the history table and the error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_vld    <= 1'b0;
            alloc_tag    <= '0;
            alloc_his    <= '0;
            rel_vld      <= 1'b0;
            rel_tag      <= '0;
            err_spurious <= 1'b0;
        end else begin
            alloc_vld    <= accept;
            rel_vld      <= rel_hit;
            err_spurious <= spurious;
            if (accept) begin
                alloc_tag <= free_tag;
                alloc_his <= his_in;
            end
            if (rel_hit) begin
                rel_tag <= cpl_tag;
            end
        end
    end

    // Drain state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Drain transitions; dropping drain_req always returns to RUN at once
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (drain_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drain_req) begin
                    state_next = ST_RUN;
                end else if (outstanding == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!drain_req) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_run     = (state == ST_RUN);
        drain_done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_req_tag_alloc.sv
// tb_req_tag_alloc: drives two allocators (full cap and cap of two) with the
// same stimulus and checks both against an in-bench model of the tag rules.
module tb_req_tag_alloc;

    localparam int TC = 8;
    localparam int TW = 3;
    localparam int HW = 4;

    logic                  clk;
    logic                  rst;
    logic                  req_vld;
    logic [HW-1:0]         req_his;
    logic                  cpl_vld;
    logic [TW-1:0]         cpl_tag;
    logic                  cpl_last;
    logic                  drain_req;

    logic [1:0]            req_rdy_w;
    logic [1:0]            alloc_vld_w;
    logic [1:0][TW-1:0]    alloc_tag_w;
    logic [1:0][HW-1:0]    alloc_his_w;
    logic [1:0]            rel_vld_w;
    logic [1:0][TW-1:0]    rel_tag_w;
    logic [1:0]            err_w;
    logic [1:0][TW:0]      outst_w;
    logic [1:0]            done_w;

    req_tag_alloc #(.TAG_COUNT(TC), .HIS_WIDTH(HW), .MAX_OUTSTANDING(8)) u_dut_full (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_his(req_his), .req_rdy(req_rdy_w[0]),
        .alloc_vld(alloc_vld_w[0]), .alloc_tag(alloc_tag_w[0]), .alloc_his(alloc_his_w[0]),
        .cpl_vld(cpl_vld), .cpl_tag(cpl_tag), .cpl_last(cpl_last),
        .rel_vld(rel_vld_w[0]), .rel_tag(rel_tag_w[0]), .err_spurious(err_w[0]),
        .outstanding(outst_w[0]), .drain_req(drain_req), .drain_done(done_w[0])
    );

    req_tag_alloc #(.TAG_COUNT(TC), .HIS_WIDTH(HW), .MAX_OUTSTANDING(2)) u_dut_cap2 (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_his(req_his), .req_rdy(req_rdy_w[1]),
        .alloc_vld(alloc_vld_w[1]), .alloc_tag(alloc_tag_w[1]), .alloc_his(alloc_his_w[1]),
        .cpl_vld(cpl_vld), .cpl_tag(cpl_tag), .cpl_last(cpl_last),
        .rel_vld(rel_vld_w[1]), .rel_tag(rel_tag_w[1]), .err_spurious(err_w[1]),
        .outstanding(outst_w[1]), .drain_req(drain_req), .drain_done(done_w[1])
    );

    // Reference model: set of held tags, drain phase, expected strobes
    int max_out[2] = '{8, 2};
    bit held[2][TC];
    int phase[2];
    bit e_avld[2];
    int e_atag[2];
    int e_ahis[2];
    bit e_rvld[2];
    int e_rtag[2];
    bit e_err[2];

    int  compared   = 0;
    int  mismatched = 0;
    bit  started    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int heldCount(int d);
        int n = 0;
        for (int i = 0; i < TC; i++) n += held[d][i] ? 1 : 0;
        return n;
    endfunction

    function automatic bit modelReady(int d);
        return (phase[d] == 0) && (heldCount(d) < TC) && (heldCount(d) < max_out[d]);
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < TC; i++) held[d][i] = 1'b0;
            phase[d] = 0;
            e_avld[d] = 0; e_atag[d] = 0; e_ahis[d] = 0;
            e_rvld[d] = 0; e_rtag[d] = 0; e_err[d] = 0;
        end
    endtask

    // One clock edge worth of allocator behaviour, from pre-edge model state
    task automatic modelStep();
        if (rst) return;
        for (int d = 0; d < 2; d++) begin
            int  cnt    = heldCount(d);
            bit  acc    = req_vld && modelReady(d);
            int  lowest = 0;
            int  ct     = int'(cpl_tag);
            bit  wasHeld = held[d][ct];
            for (int i = TC - 1; i >= 0; i--) if (!held[d][i]) lowest = i;
            e_avld[d] = acc;
            if (acc) begin
                e_atag[d] = lowest;
                e_ahis[d] = int'(req_his);
            end
            e_err[d]  = cpl_vld && !wasHeld;
            e_rvld[d] = cpl_vld && wasHeld && cpl_last;
            if (e_rvld[d]) e_rtag[d] = ct;
            if (phase[d] == 0) begin
                if (drain_req) phase[d] = 1;
            end else if (!drain_req) begin
                phase[d] = 0;
            end else if (phase[d] == 1 && cnt == 0) begin
                phase[d] = 2;
            end
            if (e_rvld[d]) held[d][ct] = 1'b0;
            if (acc) held[d][lowest] = 1'b1;
        end
    endtask

    task automatic checkVal(string name, int d, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s dut%0d at %0t: got %0d expected %0d", name, d, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        for (int d = 0; d < 2; d++) begin
            checkVal("req_rdy", d, int'(req_rdy_w[d]), int'(modelReady(d)));
            checkVal("alloc_vld", d, int'(alloc_vld_w[d]), int'(e_avld[d]));
            if (e_avld[d]) begin
                checkVal("alloc_tag", d, int'(alloc_tag_w[d]), e_atag[d]);
                checkVal("alloc_his", d, int'(alloc_his_w[d]), e_ahis[d]);
            end
            checkVal("rel_vld", d, int'(rel_vld_w[d]), int'(e_rvld[d]));
            if (e_rvld[d]) checkVal("rel_tag", d, int'(rel_tag_w[d]), e_rtag[d]);
            checkVal("err_spurious", d, int'(err_w[d]), int'(e_err[d]));
            checkVal("outstanding", d, int'(outst_w[d]), heldCount(d));
            checkVal("drain_done", d, int'(done_w[d]), int'(phase[d] == 2));
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (started) checkOutput();
    end

    task automatic cycle();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic applyStimulus(input bit rv, input int his, input bit cv,
                                 input int ct, input bit cl, input bit dr);
        req_vld   = rv;
        req_his   = HW'(his);
        cpl_vld   = cv;
        cpl_tag   = TW'(ct);
        cpl_last  = cl;
        drain_req = dr;
        cycle();
    endtask

    initial begin
        int busyList[$];
        rst = 1'b1; req_vld = 0; req_his = '0; cpl_vld = 0; cpl_tag = '0;
        cpl_last = 0; drain_req = 0;
        modelReset();
        started = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        checkVal("rst_outstanding", 0, int'(outst_w[0]), 0);
        checkVal("rst_req_rdy", 0, int'(req_rdy_w[0]), 1);
        checkVal("rst_drain_done", 0, int'(done_w[0]), 0);

        // Three back-to-back accepts
        applyStimulus(1, 'hA, 0, 0, 0, 0);
        checkVal("acc1_tag", 0, int'(alloc_tag_w[0]), 0);
        checkVal("acc1_his", 0, int'(alloc_his_w[0]), 'hA);
        applyStimulus(1, 'h5, 0, 0, 0, 0);
        checkVal("acc2_tag", 0, int'(alloc_tag_w[0]), 1);
        checkVal("acc2_his", 0, int'(alloc_his_w[0]), 'h5);
        applyStimulus(1, 'h3, 0, 0, 0, 0);
        checkVal("acc3_tag", 0, int'(alloc_tag_w[0]), 2);
        checkVal("acc3_his", 0, int'(alloc_his_w[0]), 'h3);
        checkVal("acc3_outstanding", 0, int'(outst_w[0]), 3);
        checkVal("cap_stall_vld", 1, int'(alloc_vld_w[1]), 0);
        checkVal("cap_stall_rdy", 1, int'(req_rdy_w[1]), 0);
        checkVal("cap_outstanding", 1, int'(outst_w[1]), 2);

        // Fill every tag, then free tag 5 and reuse it
        repeat (5) applyStimulus(1, int'($urandom_range(15)), 0, 0, 0, 0);
        checkVal("full_outstanding", 0, int'(outst_w[0]), 8);
        checkVal("full_rdy", 0, int'(req_rdy_w[0]), 0);
        applyStimulus(0, 0, 1, 5, 1, 0);
        checkVal("rel5_vld", 0, int'(rel_vld_w[0]), 1);
        checkVal("rel5_tag", 0, int'(rel_tag_w[0]), 5);
        checkVal("rel5_rdy", 0, int'(req_rdy_w[0]), 1);
        checkVal("rel5_spurious_cap", 1, int'(err_w[1]), 1);
        applyStimulus(1, 'h7, 0, 0, 0, 0);
        checkVal("reuse5_tag", 0, int'(alloc_tag_w[0]), 5);

        // Free tag 0 in both, next accept takes tag 0 in both
        applyStimulus(0, 0, 1, 0, 1, 0);
        applyStimulus(1, 'h9, 0, 0, 0, 0);
        checkVal("reuse0_tag", 0, int'(alloc_tag_w[0]), 0);
        checkVal("reuse0_tag", 1, int'(alloc_tag_w[1]), 0);
        checkVal("reuse0_vld", 1, int'(alloc_vld_w[1]), 1);

        // Asynchronous reset while tags are live
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        checkVal("async_outstanding", 0, int'(outst_w[0]), 0);
        checkVal("async_alloc_vld", 0, int'(alloc_vld_w[0]), 0);
        checkVal("async_rel_vld", 0, int'(rel_vld_w[0]), 0);
        cycle();
        rst = 1'b0;

        // Accept and release in the same cycle
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 2, 1, 1, 1, 0);
        checkVal("same_cycle_tag", 0, int'(alloc_tag_w[0]), 2);
        checkVal("same_cycle_rel", 0, int'(rel_tag_w[0]), 1);
        checkVal("same_cycle_outstanding", 0, int'(outst_w[0]), 2);

        // Spurious completion vs non-final completion
        applyStimulus(0, 0, 1, 6, 1, 0);
        checkVal("spur6_err", 0, int'(err_w[0]), 1);
        checkVal("spur6_rel", 0, int'(rel_vld_w[0]), 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkVal("nonlast_err", 0, int'(err_w[0]), 0);
        checkVal("nonlast_rel", 0, int'(rel_vld_w[0]), 0);
        checkVal("nonlast_outstanding", 0, int'(outst_w[0]), 2);

        // Drain with tags 0 and 2 live
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkVal("drain_rdy", 0, int'(req_rdy_w[0]), 0);
        applyStimulus(0, 0, 1, 0, 1, 1);
        checkVal("drain_first_done", 0, int'(done_w[0]), 0);
        applyStimulus(0, 0, 1, 2, 1, 1);
        checkVal("drain_second_rel", 0, int'(rel_vld_w[0]), 1);
        checkVal("drain_second_done", 0, int'(done_w[0]), 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkVal("drain_done_set", 0, int'(done_w[0]), 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkVal("drain_done_clr", 0, int'(done_w[0]), 0);
        checkVal("drain_resume_rdy", 0, int'(req_rdy_w[0]), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            bit dr = drain_req;
            int ct;
            busyList.delete();
            for (int i = 0; i < TC; i++) if (held[0][i]) busyList.push_back(i);
            if (busyList.size() > 0 && $urandom_range(9) < 7)
                ct = busyList[$urandom_range(busyList.size() - 1)];
            else
                ct = int'($urandom_range(TC - 1));
            if ($urandom_range(29) == 0) dr = !dr;
            if ($urandom_range(499) == 0) begin
                rst = 1'b1;
                modelReset();
                cycle();
                rst = 1'b0;
            end
            applyStimulus(($urandom % 3) != 0, int'($urandom_range(15)),
                          $urandom_range(1) == 1, ct, $urandom_range(3) != 0, dr);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
